// File: rtl/cla_word_serial_adder.sv
// Word-serial multi-precision add/subtract: one 16-bit CLA slice is time-shared
// across WORDS words, least-significant first, with the carry registered between words.
module carry_lookahead_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] p, g, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  assign p = a ^ b;
  assign g = a & b;

  // Two-level lookahead: 4-bit group generate/propagate, then carries into each group.
  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    gc[0] = cin;
    for (int j = 0; j < 4; j++)
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[4];
endmodule

module cla_word_serial_adder #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] op_a,
  input  logic [16*WORDS-1:0] op_b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] result,
  output logic                cout,
  output logic                overflow,
  output logic                busy
);
  localparam int W  = 16 * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [W-1:0]  a_q, b_q, result_q;
  logic          sub_q, carry_q, cout_q, ovf_q;
  logic [KW-1:0] k_q;

  logic [15:0] a_word, b_eff, sum_word;
  logic        slice_cout;

  assign a_word = a_q[{k_q, 4'b0000} +: 16];
  assign b_eff  = b_q[{k_q, 4'b0000} +: 16] ^ {16{sub_q}};

  carry_lookahead_adder_16bit u_slice (
    .a    (a_word),
    .b    (b_eff),
    .cin  (carry_q),
    .sum  (sum_word),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)         state_d = RUN;
      RUN:     if (k_q == K_LAST)    state_d = DONE;
      DONE:    if (out_ready)        state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand latch at accept, then one word per cycle in RUN; outputs frozen in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      k_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= op_a;
          b_q     <= op_b;
          sub_q   <= sub;
          carry_q <= sub ? 1'b1 : cin;
          k_q     <= '0;
        end
        RUN: begin
          result_q[{k_q, 4'b0000} +: 16] <= sum_word;
          carry_q <= slice_cout;
          if (k_q == K_LAST) begin
            cout_q <= slice_cout;
            ovf_q  <= (a_word[15] == b_eff[15]) && (sum_word[15] != a_word[15]);
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_cla_word_serial_adder.sv
// Directed bench for cla_word_serial_adder with WORDS=4 (64-bit operands).
module tb_cla_word_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow, busy;
  logic [63:0] op_a, op_b, result;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cla_word_serial_adder #(.WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .cout(cout), .overflow(overflow), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for out_valid after the accept edge; returns cycles elapsed (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic c, input logic s, input logic [63:0] exp_res,
                        input logic exp_cout, input logic exp_ovf);
    int cyc;
    @(negedge clk);
    op_a = a; op_b = b; cin = c; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = '1; op_b = '1;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(cyc);
    check({tag, "_latency"}, 64'(cyc), 64'd4);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    #1;
    check("rst_ctrl", {61'd0, in_ready, out_valid, busy}, 64'b100);
    check("rst_result", result, 64'd0);
    check("rst_flags", {62'd0, cout, overflow}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_op("ripple", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0,
           64'h0000_0000_0001_0000, 1'b0, 1'b0);
    run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
    run_op("sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_noborrow", 64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);
    run_op("sgn_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // Backpressure: hold DONE with a competing request present.
    @(negedge clk);
    op_a = 64'd3; op_b = 64'd4; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(cyc);
    check("bp_latency", 64'(cyc), 64'd4);
    @(negedge clk);
    op_a = 64'd10; op_b = 64'd20; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", {62'd0, out_valid, in_ready}, 64'b10);
      check("bp_hold_result", result, 64'd7);
      check("bp_hold_cout", 64'(cout), 64'd0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", {61'd0, in_ready, out_valid, busy}, 64'b100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_accept", {62'd0, in_ready, busy}, 64'b01);
    wait_done(cyc);
    check("bp_next_latency", 64'(cyc), 64'd4);
    check("bp_next_result", result, 64'd30);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during RUN at word index 2.
    @(negedge clk);
    op_a = 64'h1111_2222_3333_4444; op_b = 64'h0101_0101_0101_0101; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_run_partial", result[31:0], 64'h3434_4545);
    rst_n = 1'b0;
    #1;
    check("abort_ctrl", {61'd0, in_ready, out_valid, busy}, 64'b100);
    check("abort_result", result, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) cyc++;
    end
    check("abort_no_valid", 64'(cyc), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
